cv32e40x_wb_stage: RTL
======================

// Module: cv32e40x_wb_stage
// PURPOSE
// Write-back stage: consumer end of the EX/WB pipeline and of the LSU response path. Accepts
// ex_wb_pipe_i from EX, back-pressures EX via wb_ready_o, waits for/buffers the LSU response of
// loads/stores, drives the register file write port and counts retired instructions.
// Holds a one-entry LSU response buffer so a response arriving while WB is halted is never lost.
// PARAMETERS
// INSTRET_WIDTH  64  width of retire counter instret_o (wraps to 0 after all-ones)
// PORTS
// clk              in   1   clock
// rst_n            in   1   reset, synchronous, active-low
// ex_wb_pipe_i     in   ex_wb_pipe_t  EX/WB pipeline register (instr_valid, rf_we/waddr/wdata, lsu_en, illegal_insn, ...)
// ctrl_fsm_i       in   ctrl_fsm_t    uses kill_wb, halt_wb
// lsu_valid_i      in   1   LSU response valid
// lsu_ready_o      out  1   WB can accept an LSU response
// lsu_rdata_i      in   32  LSU response data (load result)
// lsu_err_i        in   1   LSU response carries bus error; qualified by lsu_valid_i
// instret_inhibit_i in  1   freeze retire counter
// wb_ready_o       out  1   WB ready for new EX/WB data
// wb_valid_o       out  1   instruction completes in WB this cycle
// rf_we_wb_o       out  1   register file write enable
// rf_waddr_wb_o    out  5   register file write address
// rf_wdata_wb_o    out  32  register file write data (also forwarded to ID)
// lsu_err_wb_o     out  1   one-cycle pulse: completing LSU instruction had bus error
// instret_o        out  INSTRET_WIDTH  retired-instruction count
// BEHAVIOUR
// - Reset (sync, rst_n=0 at posedge): resp buffer empty (resp_full_q=0, data/err 0), instret 0.
//   With buffer empty and ex_wb_pipe_i.instr_valid=0: lsu_ready_o=1, wb_ready_o=1, all others 0.
//   Reset mid-LSU-wait discards buffer; no retire counted.
// - instr_v = ex_wb_pipe_i.instr_valid && !kill_wb && !halt_wb.
// - Response buffer states: EMPTY, FULL. lsu_ready_o = (state==EMPTY).
//   EMPTY->FULL: lsu_valid_i && lsu_ready_o && !(instr_v && lsu_en) (captures rdata, err).
//   FULL->EMPTY: LSU instruction completes (instr_v && lsu_en), or kill_wb.
//   Response while EMPTY and instr_v && lsu_en: passes straight through, buffer stays EMPTY.
//   lsu_valid_i while FULL is a protocol violation (assertion).
// - resp_avail = FULL || (lsu_valid_i && lsu_ready_o); resp data/err from buffer when FULL.
// - wb_valid_o = instr_v && (!lsu_en || resp_avail). Zero-latency, combinational.
// - wb_ready_o = kill_wb || (!halt_wb && (!(ex_wb_pipe_i.instr_valid && lsu_en) || resp_avail)).
//   Non-LSU: ready whenever not halted. LSU: stalls EX until response seen.
// - rf_we_wb_o = wb_valid_o && ex_wb_pipe_i.rf_we && !(lsu_en && resp_err).
//   rf_waddr_wb_o = ex_wb_pipe_i.rf_waddr always.
//   rf_wdata_wb_o = lsu_en ? resp_data : ex_wb_pipe_i.rf_wdata.
// - lsu_err_wb_o = wb_valid_o && lsu_en && resp_err.
// - Split/misaligned first half arrives with rf_we=0: consumes its response, completes, no RF write.
// - Retire: instret += 1 at posedge when wb_valid_o && !illegal_insn && !lsu_err_wb_o &&
//   !instret_inhibit_i. Increment at all-ones wraps to 0.
// - kill_wb: wb_valid_o=0, no write, no retire, buffer flushed; same-cycle lsu_valid_i is dropped.
// - halt_wb: wb_valid_o=0, wb_ready_o=0; response during halt is buffered, completes after halt drops.
// TESTING
// - ALU instr rf_we=1 waddr=5 wdata=0xDEADBEEF, no halt -> same cycle rf_we=1, waddr=5, wdata=0xDEADBEEF, instret 0->1.
// - Load waddr=3, response 2 cycles later rdata=0x1234 -> wb_ready_o=0 two cycles, then write 0x1234, instret+1.
// - Load with halt_wb=1, response 0xAA55 arrives -> lsu_ready_o=0 next cycle; halt released -> write 0xAA55, buffer empty.
// - Load response lsu_err_i=1 -> rf_we_wb_o=0, lsu_err_wb_o=1 one cycle, instret unchanged.
// - INSTRET_WIDTH=4, instret=0xF, ALU retire -> instret=0x0; inhibit=1 -> no change.
// - kill_wb with buffer FULL -> buffer empty, wb_valid_o=0, wb_ready_o=1; sync reset mid-wait -> instret=0, lsu_ready_o=1.

Source files
------------

// File: rtl/cv32e40x_wb_stage.sv
// Write-back stage of the cv32e40x pipeline, with the EX/WB payload types in a package at the top.
// The stage consumes the EX/WB pipeline register and the LSU response stream.
// It back-pressures EX, writes the register file and counts retired instructions.
// A one-entry buffer holds an LSU response that arrives while WB is halted.
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   ex_wb_pipe_i, ctrl_fsm_i     EX/WB payload; kill/halt controls
//   lsu_valid_i/lsu_ready_o      LSU response handshake
//   lsu_rdata_i, lsu_err_i       LSU response data and bus error
//   instret_inhibit_i            freezes the retire counter
//   wb_ready_o, wb_valid_o       EX back-pressure; instruction completes this cycle
//   rf_we/waddr/wdata_wb_o       register file write port (wdata also forwarded to ID)
//   lsu_err_wb_o                 completing LSU instruction had a bus error
//   instret_o                    retired-instruction count

package cv32e40x_pkg;

  typedef struct packed {
    logic        instr_valid;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        lsu_en;
    logic        illegal_insn;
  } ex_wb_pipe_t;

  typedef struct packed {
    logic kill_wb;
    logic halt_wb;
  } ctrl_fsm_t;

endpackage

module cv32e40x_wb_stage
  import cv32e40x_pkg::*;
#(
  parameter int unsigned INSTRET_WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  ex_wb_pipe_t              ex_wb_pipe_i,
  input  ctrl_fsm_t                ctrl_fsm_i,
  input  logic                     lsu_valid_i,
  output logic                     lsu_ready_o,
  input  logic [31:0]              lsu_rdata_i,
  input  logic                     lsu_err_i,
  input  logic                     instret_inhibit_i,
  output logic                     wb_ready_o,
  output logic                     wb_valid_o,
  output logic                     rf_we_wb_o,
  output logic [4:0]               rf_waddr_wb_o,
  output logic [31:0]              rf_wdata_wb_o,
  output logic                     lsu_err_wb_o,
  output logic [INSTRET_WIDTH-1:0] instret_o
);

  localparam int unsigned DATA_W = 32;

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [DATA_W-1:0]       resp_data_q;
  logic                    resp_err_q;
  logic [INSTRET_WIDTH-1:0] instret_q;

  logic              instr_v;
  logic              lsu_instr_v;
  logic              resp_in;
  logic              resp_avail;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              capture;
  logic              retire;

  // Datapath: response selection, completion and register file write port
  always_comb begin
    instr_v     = ex_wb_pipe_i.instr_valid && !ctrl_fsm_i.kill_wb && !ctrl_fsm_i.halt_wb;
    lsu_instr_v = instr_v && ex_wb_pipe_i.lsu_en;
    lsu_ready_o = (state_q == EMPTY);
    resp_in     = lsu_valid_i && lsu_ready_o;
    resp_avail  = (state_q == FULL) || resp_in;
    resp_data   = (state_q == FULL) ? resp_data_q : lsu_rdata_i;
    resp_err    = (state_q == FULL) ? resp_err_q  : (lsu_err_i && lsu_valid_i);

    wb_valid_o  = instr_v && (!ex_wb_pipe_i.lsu_en || resp_avail);
    // A pending LSU instruction stalls EX until its response has been seen
    wb_ready_o  = ctrl_fsm_i.kill_wb ||
                  (!ctrl_fsm_i.halt_wb &&
                   (!(ex_wb_pipe_i.instr_valid && ex_wb_pipe_i.lsu_en) || resp_avail));

    rf_we_wb_o    = wb_valid_o && ex_wb_pipe_i.rf_we && !(ex_wb_pipe_i.lsu_en && resp_err);
    rf_waddr_wb_o = ex_wb_pipe_i.rf_waddr;
    rf_wdata_wb_o = ex_wb_pipe_i.lsu_en ? resp_data : ex_wb_pipe_i.rf_wdata;
    lsu_err_wb_o  = wb_valid_o && ex_wb_pipe_i.lsu_en && resp_err;

    retire      = wb_valid_o && !ex_wb_pipe_i.illegal_insn && !lsu_err_wb_o && !instret_inhibit_i;
  end

  // Response buffer next state; a kill drops both the buffer and any same-cycle response
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      EMPTY: begin
        if (resp_in && !lsu_instr_v && !ctrl_fsm_i.kill_wb) begin
          state_d = FULL;
          capture = 1'b1;
        end
      end
      FULL: begin
        if (lsu_instr_v || ctrl_fsm_i.kill_wb) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Buffer state and payload
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      resp_data_q <= '0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        resp_data_q <= lsu_rdata_i;
        resp_err_q  <= lsu_err_i;
      end
    end
  end

  // Retire counter, wraps naturally at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + INSTRET_WIDTH'(1);
    end
  end

  assign instret_o = instret_q;

  // The LSU must not present a response while the buffer is occupied
  a_no_resp_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    !(lsu_valid_i && (state_q == FULL)));

endmodule
